// File: rtl/btn_input_conditioner.sv
// Purpose : turns raw push-button levels into one-hot single-cycle commands (sync, debounce, press pulse, arbitration, auto-repeat).
// Latency : a raw press first sampled at edge 1 produces a debounced level at edge DEBOUNCE_CYCLES+2 and a pulse after edge DEBOUNCE_CYCLES+3.
// Backpressure: none; the consumer cannot stall. i_en = 0 drops events and the block never queues them.
//
// Ports:
//   w_clk        system clock
//   w_rst_n      asynchronous active-low reset, released synchronously
//   i_btn        raw asynchronous button levels, 1 = pressed
//   i_en         command enable; 0 suppresses every output pulse
//   o_user_input registered one-hot command pulse (INC=bit0, DEC=bit1, OK=bit2), or all-zero
//   o_btn_level  debounced button levels
//
// N_BTN must be at least 3, because the fixed priority order names bits 2, 1 and 0.
module btn_input_conditioner #(
    parameter int               N_BTN           = 4,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter int               REPEAT_DELAY    = 50000000,
    parameter int               REPEAT_PERIOD   = 15000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(4'b0011)
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic [N_BTN-1:0] i_btn,
    input  logic             i_en,
    output logic [N_BTN-1:0] o_user_input,
    output logic [N_BTN-1:0] o_btn_level
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = $clog2(RC_MAX + 1);
    localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] armed;
    logic [1:0]       prime_sr;
    logic [DB_W-1:0]  db_cnt [N_BTN];

    logic [N_BTN-1:0] press_ev;
    logic [N_BTN-1:0] press_gnt;
    logic             rep_abort;
    logic [RC_W-1:0]  rep_last;

    rep_state_t       state;
    rep_state_t       state_nxt;
    logic [N_BTN-1:0] held;
    logic [N_BTN-1:0] held_nxt;
    logic [RC_W-1:0]  rep_cnt;
    logic [RC_W-1:0]  rep_cnt_nxt;
    logic [N_BTN-1:0] user_nxt;

    // Two-flop synchroniser. A button only becomes eligible for press
    // events once it has been seen released after reset (prime_sr waits
    // until sync2 carries a real sample), so a button held through reset
    // has to be let go and pressed again.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            prime_sr <= '0;
            armed    <= '0;
        end else begin
            sync1    <= i_btn;
            sync2    <= sync1;
            prime_sr <= {prime_sr[0], 1'b1};
            if (prime_sr[1]) begin
                armed <= armed | ~sync2;
            end
        end
    end

    // Per-bit debounce: the synchronised level must disagree with the
    // accepted level for DEBOUNCE_CYCLES consecutive edges before it is taken.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            level   <= '0;
            level_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            level_q <= level;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press_ev = level & ~level_q & armed;

    // Fixed priority OK(2) > DEC(1) > INC(0) > 3 > higher indices. Later
    // assignments override earlier ones, so the walk runs from the lowest
    // priority up. Losers are simply dropped.
    always_comb begin
        press_gnt = '0;
        for (int i = N_BTN - 1; i >= 3; i--) begin
            if (press_ev[i]) begin
                press_gnt    = '0;
                press_gnt[i] = 1'b1;
            end
        end
        if (press_ev[0]) begin
            press_gnt    = '0;
            press_gnt[0] = 1'b1;
        end
        if (press_ev[1]) begin
            press_gnt    = '0;
            press_gnt[1] = 1'b1;
        end
        if (press_ev[2]) begin
            press_gnt    = '0;
            press_gnt[2] = 1'b1;
        end
    end

    // Repeating stops as soon as the held button is released or any other
    // button is down; held is one-hot while DELAY/REPEAT are active.
    assign rep_abort = ((level & held) == '0) || ((level & ~held) != '0);
    assign rep_last  = (state == DELAY) ? RD_LAST : RP_LAST;

    always_comb begin
        state_nxt   = state;
        held_nxt    = held;
        rep_cnt_nxt = rep_cnt;
        user_nxt    = '0;

        if (!i_en) begin
            state_nxt = IDLE;
        end else if (press_gnt != '0) begin
            // A fresh press always wins over a pending repeat.
            user_nxt = press_gnt;
            if ((press_gnt & REPEAT_MASK) != '0) begin
                state_nxt   = DELAY;
                held_nxt    = press_gnt;
                rep_cnt_nxt = '0;
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                DELAY, REPEAT: begin
                    if (rep_abort) begin
                        state_nxt = IDLE;
                    end else if (rep_cnt == rep_last) begin
                        user_nxt    = held;
                        state_nxt   = REPEAT;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state        <= IDLE;
            held         <= '0;
            rep_cnt      <= '0;
            o_user_input <= '0;
        end else begin
            state        <= state_nxt;
            held         <= held_nxt;
            rep_cnt      <= rep_cnt_nxt;
            o_user_input <= user_nxt;
        end
    end

    assign o_btn_level = level;

endmodule

// File: tb/tb_btn_input_conditioner.sv
// Purpose : exercises btn_input_conditioner with small timing parameters against a cycle-level reference model.
// Latency : the model is stepped at each rising edge and outputs are compared 1 ns after it.
// Backpressure: not applicable; stimulus is driven freely from a single process.
module tb_btn_input_conditioner;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam logic [N-1:0] MASK = 4'b0011;

    logic         w_clk   = 1'b0;
    logic         w_rst_n = 1'b0;
    logic [N-1:0] i_btn   = '0;
    logic         i_en    = 1'b0;
    logic [N-1:0] o_user_input;
    logic [N-1:0] o_btn_level;

    btn_input_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (MASK)
    ) dut (
        .w_clk        (w_clk),
        .w_rst_n      (w_rst_n),
        .i_btn        (i_btn),
        .i_en         (i_en),
        .o_user_input (o_user_input),
        .o_btn_level  (o_btn_level)
    );

    always #5 w_clk = ~w_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state as seen just after each rising edge.
    int           m_edge;
    logic [N-1:0] m_s1, m_s, m_level, m_level_q, m_armed, m_out;
    logic [N-1:0] m_hist [D];
    bit           m_rep_on;
    int           m_rep_bit;
    int           m_rep_next;
    int           prio_order [4] = '{2, 1, 0, 3};

    function automatic void model_reset();
        m_edge    = 0;
        m_s1      = '0;
        m_s       = '0;
        m_level   = '0;
        m_level_q = '0;
        m_armed   = '0;
        m_out     = '0;
        m_rep_on  = 1'b0;
        m_rep_bit = 0;
        m_rep_next = 0;
        for (int k = 0; k < D; k++) m_hist[k] = '0;
    endfunction

    function automatic int pick(input logic [N-1:0] ev);
        for (int k = 0; k < 4; k++) begin
            if (ev[prio_order[k]]) return prio_order[k];
        end
        return -1;
    endfunction

    function automatic void model_step();
        logic [N-1:0] ev, others, new_lvl;
        int g;
        bit all_diff;
        m_edge++;
        ev    = m_level & ~m_level_q & m_armed;
        m_out = '0;
        if (!i_en) begin
            m_rep_on = 1'b0;
        end else if (ev != '0) begin
            g = pick(ev);
            m_out[g] = 1'b1;
            if (MASK[g]) begin
                m_rep_on   = 1'b1;
                m_rep_bit  = g;
                m_rep_next = m_edge + RD;
            end else begin
                m_rep_on = 1'b0;
            end
        end else if (m_rep_on) begin
            others = m_level;
            others[m_rep_bit] = 1'b0;
            if (!m_level[m_rep_bit] || others != '0) begin
                m_rep_on = 1'b0;
            end else if (m_edge == m_rep_next) begin
                m_out[m_rep_bit] = 1'b1;
                m_rep_next = m_edge + RP;
            end
        end
        // Level flips when the last D synchronised samples all disagree with it.
        for (int k = D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_s;
        new_lvl = m_level;
        for (int i = 0; i < N; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) begin
                if (m_hist[k][i] == m_level[i]) all_diff = 1'b0;
            end
            if (all_diff) new_lvl[i] = ~m_level[i];
        end
        m_level_q = m_level;
        m_level   = new_lvl;
        m_s  = m_s1;
        m_s1 = i_btn;
        if (m_edge >= 2) m_armed = m_armed | ~i_btn;
    endfunction

    task automatic tick();
        @(posedge w_clk);
        if (w_rst_n) model_step();
        else model_reset();
        #1;
        check_val("out", o_user_input, m_out);
        check_val("lvl", o_btn_level, m_level);
    endtask

    task automatic wait_pulse(input string tag, input int bound);
        int k = 0;
        do begin
            tick();
            k++;
        end while (o_user_input == '0 && k < bound);
        check_val(tag, (o_user_input != '0), 1);
    endtask

    int           pulses;
    logic [N-1:0] acc;
    logic [N-1:0] first_pulse;
    logic [N-1:0] exp_rep;

    initial begin
        model_reset();
        i_en = 1'b1;
        #12;
        check_val("rst_out", o_user_input, 0);
        check_val("rst_lvl", o_btn_level, 0);
        #10 w_rst_n = 1'b1;
        repeat (6) tick();

        // Single OK press: level after edge D+2, pulse only after edge D+3.
        i_btn  = 4'b0100;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == D + 1) check_val("s1_lvl_early", o_btn_level[2], 0);
            if (k == D + 2) check_val("s1_lvl_rise", o_btn_level[2], 1);
            if (k == D + 2) check_val("s1_out_early", o_user_input, 0);
            if (k == D + 3) check_val("s1_out_pulse", o_user_input, 4'b0100);
            if (k == D + 4) check_val("s1_out_clear", o_user_input, 0);
            if (o_user_input != '0) pulses++;
        end
        check_val("s1_pulse_cnt", pulses, 1);
        i_btn  = '0;
        pulses = 0;
        repeat (12) begin
            tick();
            if (o_user_input != '0) pulses++;
        end
        check_val("s1_release", pulses, 0);

        // Glitch shorter than the debounce window.
        acc   = '0;
        i_btn = 4'b0001;
        repeat (3) begin tick(); acc = acc | o_user_input | o_btn_level; end
        i_btn = '0;
        repeat (10) begin tick(); acc = acc | o_user_input | o_btn_level; end
        check_val("s2_glitch", acc, 0);

        // Simultaneous presses: OK wins, no INC/DEC pulse and no repeat.
        i_btn       = 4'b0111;
        pulses      = 0;
        first_pulse = '0;
        for (int k = 0; k < 26; k++) begin
            if (k == 6) i_btn = 4'b0011;
            tick();
            if (o_user_input != '0) begin
                pulses++;
                if (first_pulse == '0) first_pulse = o_user_input;
            end
        end
        check_val("s3_pulse_cnt", pulses, 1);
        check_val("s3_winner", first_pulse, 4'b0100);
        i_btn = '0;
        repeat (12) tick();

        // DEC held: pulses at +0, +RD, then every RP.
        i_btn = 4'b0010;
        wait_pulse("s4_wait_press", 20);
        check_val("s4_press", o_user_input, 4'b0010);
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_rep = (k >= RD && ((k - RD) % RP) == 0) ? 4'b0010 : 4'b0000;
            check_val("s4_repeat", o_user_input, exp_rep);
            if (o_user_input != '0) pulses++;
        end
        check_val("s4_repeat_cnt", pulses, 7);
        i_btn = '0;
        repeat (15) tick();

        // Press while disabled, enable while held: no pulse.
        i_en   = 1'b0;
        i_btn  = 4'b0001;
        pulses = 0;
        repeat (10) begin tick(); if (o_user_input != '0) pulses++; end
        i_en = 1'b1;
        repeat (10) begin tick(); if (o_user_input != '0) pulses++; end
        check_val("s5_en_held", pulses, 0);
        i_btn = '0;
        repeat (10) tick();
        i_btn = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == D + 3) check_val("s5_repress", o_user_input, 4'b0001);
        end
        i_btn = '0;
        repeat (12) tick();

        // Asynchronous reset in the middle of auto-repeat.
        i_btn = 4'b0001;
        wait_pulse("s6_wait_press", 20);
        wait_pulse("s6_wait_repeat", 20);
        #2 w_rst_n = 1'b0;
        #1;
        check_val("s6_async_out", o_user_input, 0);
        check_val("s6_async_lvl", o_btn_level, 0);
        repeat (3) tick();
        #3 w_rst_n = 1'b1;
        pulses = 0;
        repeat (25) begin tick(); if (o_user_input != '0) pulses++; end
        check_val("s6_held_after_rst", pulses, 0);
        i_btn = '0;
        repeat (10) tick();
        i_btn  = 4'b0001;
        pulses = 0;
        repeat (12) begin tick(); if (o_user_input != '0) pulses++; end
        check_val("s6_repress", pulses, 1);
        i_btn = '0;
        repeat (12) tick();

        // Randomised mix of presses, glitches, chords and enable drops.
        repeat (300) begin
            int r;
            int dur;
            r = $urandom_range(0, 9);
            if (r < 4)      i_btn = 4'b0001 << $urandom_range(0, 1);
            else if (r < 6) i_btn = 4'b0100 << $urandom_range(0, 1);
            else if (r < 8) i_btn = 4'($urandom_range(0, 15));
            else            i_btn = '0;
            i_en = ($urandom_range(0, 9) != 0);
            dur  = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 40);
            repeat (dur) tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_input_conditioner.md
Name: btn_input_conditioner

Overview:
Conditions the raw push-button inputs of the Connect-Four board and produces the one-hot, single-cycle command word consumed by the game controller's `w_user_input` port (INC = bit0, DEC = bit1, OK = bit2, bit3 spare). It does the following:
- synchronises each button;
- debounces it;
- converts each debounced press into exactly one pulse;
- arbitrates simultaneous presses;
- auto-repeats INC/DEC while held, so column selection can scroll.

Parameters:
- N_BTN, 4, number of buttons; bit i of i_btn maps to bit i of o_user_input.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised level must differ from the debounced level before it is accepted (10 ms at 100 MHz); must be >= 1.
- REPEAT_DELAY, 50000000, cycles from a press pulse to the first auto-repeat pulse.
- REPEAT_PERIOD, 15000000, cycles between subsequent auto-repeat pulses.
- REPEAT_MASK, 4'b0011, buttons eligible for auto-repeat (INC, DEC).

Ports:
- w_clk  input  1  system clock.
- w_rst_n  input  1  reset, asynchronous assert, active-low.
- i_btn  input  N_BTN  raw button levels, asynchronous, 1 = pressed.
- i_en  input  1  accept commands; 0 suppresses all output pulses.
- o_user_input  output  N_BTN  one-hot command pulse, or all-zero.
- o_btn_level  output  N_BTN  debounced button levels.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While w_rst_n = 0, every flop clears immediately:
  - synchronisers, debounced levels and debounce counters;
  - repeat counter and held-button register;
  - o_user_input = 0 and o_btn_level = 0.
  - Release is synchronous to w_clk. A reset mid-hold gives no pulse after release, even if the button is still held; the button must be released and pressed again.
- Synchroniser: two flops per bit. Let s_i be the second flop.
- Debounce, per bit, with counter width $clog2(DEBOUNCE_CYCLES+1):
  - If s_i == level_i, the counter clears to 0.
  - Otherwise the counter increments. On the edge where it would reach DEBOUNCE_CYCLES, level_i <= s_i and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes level_i.
  - o_btn_level = level.
- Press event: level_i rising, i.e. 0 -> 1 on that edge. Release generates nothing.
- Latency: raw i_btn first sampled high at edge 1 and held. level rises at edge DEBOUNCE_CYCLES+2. o_user_input bit is high for exactly the cycle after edge DEBOUNCE_CYCLES+3.
- Output register: o_user_input is registered and has at most one bit set per cycle. It returns to 0 the next cycle unless another event is granted.
- Arbitration when several events occur on the same edge:
  - Fixed priority: bit2 (OK) > bit1 > bit0 > bit3 > higher indices.
  - Losing events are dropped, not queued.
  - A new press event always beats a pending repeat event.
- Auto-repeat FSM, states IDLE, DELAY, REPEAT:
  - Any state -> IDLE: on any press pulse of a non-REPEAT_MASK button.
  - IDLE -> DELAY: when a press pulse is emitted for a REPEAT_MASK button. The held register <= that bit; the counter <= 0.
  - DELAY: counts cycles. On reaching REPEAT_DELAY-1 it emits the held bit and goes to REPEAT with the counter cleared.
  - REPEAT: emits the held bit every REPEAT_PERIOD cycles.
  - DELAY/REPEAT -> IDLE immediately, with no pulse, if level[held] falls or any other level bit is 1.
  - A new masked press while in DELAY/REPEAT re-arms DELAY for the new button.
- i_en = 0:
  - o_user_input forced to 0 on the next edge, and events are dropped.
  - FSM to IDLE.
  - Debounce and o_btn_level continue normally.
  - Raising i_en while a button is held yields no pulse, because output is edge-based.

Test Plan:
- Parameters DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3, en = 1. Hold i_btn = 4'b0100 from edge 1 -> o_btn_level[2] = 1 after edge 6; o_user_input = 4'b0100 only after edge 7; 0 after edge 8; no further pulses; release gives no pulse.
- Raw bit0 glitch high for 3 cycles, then low -> o_btn_level and o_user_input stay 0 throughout.
- i_btn 4'b0000 -> 4'b0111 in one cycle, held 6 cycles, then 4'b0011 -> single pulse 4'b0100; no INC/DEC pulse and no repeat (multiple levels high).
- Hold bit1 for 30 cycles after its press pulse -> pulses at press+0, +10, +13, +16, ... +28 (all 4'b0010); release stops pulses within 1 cycle of level falling.
- Hold bit0 with i_en = 0, raise i_en while held -> no pulse; release and re-press -> one 4'b0001 pulse after DEBOUNCE_CYCLES+3 edges.
- Assert w_rst_n = 0 asynchronously mid-repeat (between edges) -> o_user_input and o_btn_level read 0 before the next edge; after release, still-held button gives no pulse until re-pressed.
